blockade_load_ctrl: RTL and testbench

- Sequences the HPS ioctl download stream into the Blockade-family core.
- Routes ROM bytes (index 0) to the core download port, latches the game-mode byte (index 1) and DIP byte 0 (index 254), and tracks whether any non-zero ROM data was received.
- Owns the core reset: holds the core in reset until a valid ROM exists, then releases it after a fixed hold-off. This stops the sound circuit from running with no ROM loaded.
- Sits in emu between hps_io and blockade, running on clk_sys.

---
 rtl/blockade_load_ctrl_if.sv | 31 +++
 rtl/blockade_load_ctrl.sv | 157 +++++++++++++++
 tb/tb_blockade_load_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/blockade_load_ctrl_if.sv
// Signal bundle between hps_io's ioctl download stream, the Blockade core's
// ROM download port, and the config/reset outputs of the load controller.
interface blockade_load_ctrl_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        user_reset;

  logic [13:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic [1:0]  game_mode;
  logic [7:0]  dip_sw0;
  logic        core_reset;
  logic        loading;
  logic        rom_ok;

  // Host side: hps_io / OSD drive the download stream and the user reset.
  modport master (
    output ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout, user_reset,
    input  dn_addr, dn_data, dn_wr, game_mode, dip_sw0, core_reset, loading, rom_ok
  );

  // Controller side.
  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout, user_reset,
    output dn_addr, dn_data, dn_wr, game_mode, dip_sw0, core_reset, loading, rom_ok
  );
endinterface

// File: rtl/blockade_load_ctrl.sv
// Blockade-family download sequencer: forwards ROM bytes to the core, latches
// game mode / DIP settings, and keeps the core in reset until a usable ROM exists.
module blockade_load_ctrl #(
  parameter int unsigned ROM_SIZE    = 16384,
  parameter int unsigned HOLD_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  blockade_load_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    NOROM = 2'd0,
    LOAD  = 2'd1,
    HOLD  = 2'd2,
    RUN   = 2'd3
  } state_e;

  localparam logic [15:0] HOLD_LOAD  = 16'(HOLD_CYCLES - 1);
  localparam logic [24:0] ROM_LIMIT  = 25'(ROM_SIZE);
  localparam logic [7:0]  IDX_ROM    = 8'd0;
  localparam logic [7:0]  IDX_MODE   = 8'd1;
  localparam logic [7:0]  IDX_DIP    = 8'd254;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        nz_q, nz_d;
  logic        rom_ok_q, rom_ok_d;
  logic        core_reset_q;
  logic        loading_q;
  logic [13:0] dn_addr_q;
  logic [7:0]  dn_data_q;
  logic        dn_wr_q;
  logic [1:0]  game_mode_q;
  logic [7:0]  dip_sw0_q;

  logic dl_active;
  logic rom_wr;
  logic rom_fwd;
  logic rom_nz;
  logic cfg_at_zero;

  assign dl_active   = bus.ioctl_download && (bus.ioctl_index == IDX_ROM);
  assign rom_wr      = bus.ioctl_wr && dl_active;
  // rom_wr implies an index-0 download, so outside LOAD it also starts a load
  // on the same edge; forwarding therefore needs no extra state qualifier.
  assign rom_fwd     = rom_wr && (bus.ioctl_addr < ROM_LIMIT);
  assign rom_nz      = rom_fwd && (bus.ioctl_dout != 8'h00);
  assign cfg_at_zero = bus.ioctl_wr && (bus.ioctl_addr == 25'd0);

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    nz_d     = nz_q;
    rom_ok_d = rom_ok_q;

    unique case (state_q)
      NOROM: begin
        if (dl_active) begin
          state_d = LOAD;
          nz_d    = rom_nz;
        end
      end

      LOAD: begin
        if (!dl_active) begin
          // A pending user_reset is absorbed here: HOLD starts with a full count anyway.
          if (nz_q) begin
            state_d  = HOLD;
            rom_ok_d = 1'b1;
            cnt_d    = HOLD_LOAD;
          end else begin
            state_d  = NOROM;
            rom_ok_d = 1'b0;
          end
        end else if (rom_nz) begin
          nz_d = 1'b1;
        end
      end

      HOLD: begin
        if (dl_active) begin
          state_d = LOAD;
          nz_d    = rom_nz;
        end else if (bus.user_reset) begin
          cnt_d = HOLD_LOAD;
        end else if (cnt_q == 16'd0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      RUN: begin
        if (dl_active) begin
          state_d = LOAD;
          nz_d    = rom_nz;
        end else if (bus.user_reset) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end

      default: state_d = NOROM;
    endcase
  end

  // Outputs are registered from the next state so core_reset and loading
  // track the state register exactly, without a combinational path to the core.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= NOROM;
      cnt_q        <= 16'd0;
      nz_q         <= 1'b0;
      rom_ok_q     <= 1'b0;
      core_reset_q <= 1'b1;
      loading_q    <= 1'b0;
      dn_addr_q    <= 14'd0;
      dn_data_q    <= 8'd0;
      dn_wr_q      <= 1'b0;
      game_mode_q  <= 2'd0;
      dip_sw0_q    <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      nz_q         <= nz_d;
      rom_ok_q     <= rom_ok_d;
      core_reset_q <= (state_d != RUN);
      loading_q    <= (state_d == LOAD);

      dn_wr_q <= rom_fwd;
      if (rom_fwd) begin
        dn_addr_q <= bus.ioctl_addr[13:0];
        dn_data_q <= bus.ioctl_dout;
      end

      if (cfg_at_zero && (bus.ioctl_index == IDX_MODE)) begin
        game_mode_q <= bus.ioctl_dout[1:0];
      end
      if (cfg_at_zero && (bus.ioctl_index == IDX_DIP)) begin
        dip_sw0_q <= bus.ioctl_dout;
      end
    end
  end

  assign bus.dn_addr    = dn_addr_q;
  assign bus.dn_data    = dn_data_q;
  assign bus.dn_wr      = dn_wr_q;
  assign bus.game_mode  = game_mode_q;
  assign bus.dip_sw0    = dip_sw0_q;
  assign bus.core_reset = core_reset_q;
  assign bus.loading    = loading_q;
  assign bus.rom_ok     = rom_ok_q;

endmodule

// File: tb/tb_blockade_load_ctrl.sv
// Directed bench for blockade_load_ctrl: ROM forwarding, hold-off timing,
// zero-ROM rejection, config latches and asynchronous reset.
module tb_blockade_load_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  blockade_load_ctrl_if bus ();

  blockade_load_ctrl #(
    .ROM_SIZE   (16384),
    .HOLD_CYCLES(1024)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".dn_addr"},    32'(bus.dn_addr),    32'h0);
    check({tag, ".dn_data"},    32'(bus.dn_data),    32'h0);
    check({tag, ".dn_wr"},      32'(bus.dn_wr),      32'h0);
    check({tag, ".game_mode"},  32'(bus.game_mode),  32'h0);
    check({tag, ".dip_sw0"},    32'(bus.dip_sw0),    32'h0);
    check({tag, ".core_reset"}, 32'(bus.core_reset), 32'h1);
    check({tag, ".loading"},    32'(bus.loading),    32'h0);
    check({tag, ".rom_ok"},     32'(bus.rom_ok),     32'h0);
  endtask

  // ROM byte write; dn_* must show it right after the sampling edge.
  task automatic rom_write(input string tag, input logic [24:0] addr, input logic [7:0] data,
                           input bit expect_fwd, input logic [13:0] hold_addr);
    bus.ioctl_index = 8'd0;
    bus.ioctl_addr  = addr;
    bus.ioctl_dout  = data;
    bus.ioctl_wr    = 1'b1;
    tick();
    bus.ioctl_wr = 1'b0;
    check({tag, ".dn_wr"}, 32'(bus.dn_wr), 32'(expect_fwd));
    check({tag, ".dn_addr"}, 32'(bus.dn_addr), expect_fwd ? 32'(addr[13:0]) : 32'(hold_addr));
    if (expect_fwd) check({tag, ".dn_data"}, 32'(bus.dn_data), 32'(data));
    check({tag, ".loading"}, 32'(bus.loading), 32'h1);
    tick();
    check({tag, ".dn_wr_off"}, 32'(bus.dn_wr), 32'h0);
  endtask

  task automatic cfg_write(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
    bus.ioctl_index = idx;
    bus.ioctl_addr  = addr;
    bus.ioctl_dout  = data;
    bus.ioctl_wr    = 1'b1;
    tick();
    bus.ioctl_wr = 1'b0;
  endtask

  // Count cycles until core_reset drops; bounded so a stuck DUT still ends.
  task automatic measure_hold(input string tag);
    int n = 0;
    while (bus.core_reset && n < 2000) begin
      tick();
      n++;
    end
    check({tag, ".hold_cycles"}, 32'(n), 32'd1024);
    check({tag, ".core_reset"}, 32'(bus.core_reset), 32'h0);
  endtask

  initial begin
    bit saw_release;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_addr     = 25'd0;
    bus.ioctl_dout     = 8'd0;
    bus.user_reset     = 1'b0;

    #12;
    check_reset_vals("reset");
    reset_n = 1'b1;
    repeat (30) tick();
    check_reset_vals("idle");

    // Good ROM: 00 3E 00
    bus.ioctl_download = 1'b1;
    tick();
    check("load1.loading", 32'(bus.loading), 32'h1);
    rom_write("load1.b0", 25'd0, 8'h00, 1'b1, 14'd0);
    rom_write("load1.b1", 25'd1, 8'h3E, 1'b1, 14'd0);
    rom_write("load1.b2", 25'd2, 8'h00, 1'b1, 14'd0);
    bus.ioctl_download = 1'b0;
    tick();
    check("load1.loading_off", 32'(bus.loading), 32'h0);
    check("load1.rom_ok", 32'(bus.rom_ok), 32'h1);
    measure_hold("load1");

    // All-zero ROM, started together with user_reset: LOAD must win.
    bus.ioctl_download = 1'b1;
    bus.user_reset     = 1'b1;
    tick();
    bus.user_reset = 1'b0;
    check("zero.loading", 32'(bus.loading), 32'h1);
    check("zero.core_reset", 32'(bus.core_reset), 32'h1);
    for (int i = 0; i < 16; i++) begin
      bus.ioctl_addr = 25'(i);
      bus.ioctl_dout = 8'h00;
      bus.ioctl_wr   = 1'b1;
      tick();
      bus.ioctl_wr = 1'b0;
      tick();
    end
    bus.ioctl_download = 1'b0;
    tick();
    check("zero.rom_ok", 32'(bus.rom_ok), 32'h0);
    saw_release = 1'b0;
    repeat (1100) begin
      tick();
      if (!bus.core_reset) saw_release = 1'b1;
    end
    check("zero.never_released", 32'(saw_release), 32'h0);

    // Out-of-range write is dropped; dn_addr holds the last forwarded address.
    bus.ioctl_download = 1'b1;
    tick();
    rom_write("oor.b5", 25'd5, 8'h10, 1'b1, 14'd0);
    rom_write("oor.x4000", 25'h4000, 8'h55, 1'b0, 14'd5);
    bus.ioctl_download = 1'b0;
    tick();
    check("oor.rom_ok", 32'(bus.rom_ok), 32'h1);
    measure_hold("oor");

    // user_reset pulse in RUN
    bus.user_reset = 1'b1;
    tick();
    bus.user_reset = 1'b0;
    check("ureset.asserted", 32'(bus.core_reset), 32'h1);
    measure_hold("ureset");

    // Config latches in RUN
    cfg_write(8'd1, 25'd0, 8'h03);
    check("cfg.game_mode", 32'(bus.game_mode), 32'h3);
    check("cfg.core_reset", 32'(bus.core_reset), 32'h0);
    cfg_write(8'd254, 25'd0, 8'hA5);
    check("cfg.dip_sw0", 32'(bus.dip_sw0), 32'hA5);
    cfg_write(8'd254, 25'd1, 8'h11);
    check("cfg.dip_addr1", 32'(bus.dip_sw0), 32'hA5);
    cfg_write(8'd1, 25'd1, 8'h01);
    check("cfg.mode_addr1", 32'(bus.game_mode), 32'h3);
    check("cfg.dn_wr", 32'(bus.dn_wr), 32'h0);
    check("cfg.core_reset2", 32'(bus.core_reset), 32'h0);

    // Async reset mid-load, away from any clock edge.
    bus.ioctl_index    = 8'd0;
    bus.ioctl_download = 1'b1;
    tick();
    rom_write("areset.b0", 25'd0, 8'h22, 1'b1, 14'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals("areset");
    bus.ioctl_download = 1'b0;
    #10;
    reset_n = 1'b1;
    tick();

    // Full reload after reset
    bus.ioctl_download = 1'b1;
    tick();
    rom_write("reload.b0", 25'd0, 8'h01, 1'b1, 14'd0);
    rom_write("reload.b1", 25'd1, 8'h80, 1'b1, 14'd0);
    bus.ioctl_download = 1'b0;
    tick();
    check("reload.rom_ok", 32'(bus.rom_ok), 32'h1);
    measure_hold("reload");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
